// File: rtl/dem_dwa_sched.sv
// dem_dwa_sched: sample strobe, LFSR dither and DWA rotated element select with IDLE/WARMUP/RUN/DRAIN sequencing.
// Optional `DEM_PTR_DITHER_EN adds lfsr[1] to the rotation pointer advance.
module dem_dwa_sched #(
  parameter int          N_ELEM = 8,
  parameter int          PTR_W  = 3,
  parameter int          DIV    = 4,
  parameter int          WARMUP = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [PTR_W:0]    V,
  output logic              clk_en,
  output logic [1:0]        dither,
  output logic [N_ELEM-1:0] sel,
  output logic [PTR_W-1:0]  ptr,
  output logic              busy,
  output logic              v_err
);
  localparam int CW = $clog2(DIV);
  localparam int WW = $clog2(WARMUP + 1);
  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN} state_t;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WW-1:0]       warm_cnt;
  logic [15:0]         lfsr;
  logic                over;
  logic [PTR_W:0]      ve;
  logic [PTR_W-1:0]    psum;
  logic [2*N_ELEM-1:0] rot;
  logic [N_ELEM-1:0]   nsel;
  always_comb begin
    over = V > (PTR_W+1)'(N_ELEM);
    ve   = over ? (PTR_W+1)'(N_ELEM) : V;
    // thermometer of ve ones, rotated by ptr; the upper half folds back onto the lower
    rot  = (((2*N_ELEM)'(1) << ve) - (2*N_ELEM)'(1)) << ptr;
    nsel = rot[N_ELEM-1:0] | rot[2*N_ELEM-1:N_ELEM];
`ifdef DEM_PTR_DITHER_EN
    psum = PTR_W'({1'b0, ptr} + ve + (PTR_W+1)'(lfsr[1]));
`else
    psum = PTR_W'({1'b0, ptr} + ve);
`endif
  end
  assign busy   = state != S_IDLE;
  assign clk_en = busy && cnt == CW'(DIV - 1);
  assign dither = lfsr[0] ? 2'b01 : 2'b11;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      warm_cnt <= '0;
      ptr      <= '0;
      sel      <= '0;
      lfsr     <= SEED;
      v_err    <= 1'b0;
    end else begin
      cnt <= (!busy || clk_en) ? '0 : cnt + 1'b1;
      if (clk_en && (state == S_WARM || state == S_RUN))
        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      case (state)
        S_IDLE: if (run) begin
          state    <= S_WARM;
          warm_cnt <= '0;
        end
        S_WARM: if (!run) begin
          state    <= S_IDLE;
          cnt      <= '0;
          warm_cnt <= '0;
        end else if (clk_en) begin
          warm_cnt <= (warm_cnt == WW'(WARMUP - 1)) ? '0 : warm_cnt + 1'b1;
          if (warm_cnt == WW'(WARMUP - 1)) state <= S_RUN;
        end
        S_RUN: if (!run) state <= S_DRAIN;
        else if (clk_en) begin
          sel <= nsel;
          ptr <= psum;
          if (over) v_err <= 1'b1;
        end
        default: if (clk_en) begin
          sel   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dem_dwa_sched.sv
// tb_dem_dwa_sched: directed plus randomized checks of dem_dwa_sched against a phase/count reference model.
module tb_dem_dwa_sched;
  localparam int N = 8, DIV = 4, WARMUP = 16;
  logic       clk = 0, rstn = 0, run = 0;
  logic [3:0] V = 0;
  logic       clk_en, busy, v_err;
  logic [1:0] dither;
  logic [7:0] sel;
  logic [2:0] ptr;
  int npass = 0, ntotal = 0;
  string      mph = "idle";
  int         mcnt = 0, mwc = 0, mptr = 0;
  logic [7:0] msel = 0;
  logic [15:0] ml = 16'hACE1;
  bit         mverr = 0, mse = 0;

  dem_dwa_sched #(.N_ELEM(N), .PTR_W(3), .DIV(DIV), .WARMUP(WARMUP), .SEED(16'hACE1)) dut (
    .clk(clk), .rstn(rstn), .run(run), .V(V), .clk_en(clk_en), .dither(dither),
    .sel(sel), .ptr(ptr), .busy(busy), .v_err(v_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & 16'h002D), l[15:1]};
  endfunction

  task automatic model_edge(input bit rs, input bit r, input int v);
    int ve;
    mse = (mph != "idle") && mcnt == DIV - 1;
    if (!rs) begin
      mph = "idle"; mcnt = 0; mwc = 0; mptr = 0; msel = 0; ml = 16'hACE1; mverr = 0;
      return;
    end
    if (mse && (mph == "warm" || mph == "run")) ml = lfsr_next(ml);
    if (mph == "idle") begin
      if (r) begin mph = "warm"; mwc = 0; end
    end else if (mph == "warm") begin
      if (!r) begin mph = "idle"; mcnt = 0; mwc = 0; end
      else begin
        mcnt = (mcnt + 1) % DIV;
        if (mse) begin mwc++; if (mwc == WARMUP) mph = "run"; end
      end
    end else if (mph == "run") begin
      mcnt = (mcnt + 1) % DIV;
      if (!r) mph = "drain";
      else if (mse) begin
        ve = v > N ? N : v;
        if (v > N) mverr = 1;
        msel = 0;
        for (int k = 0; k < ve; k++) msel[(mptr + k) % N] = 1'b1;
        mptr = (mptr + ve) % N;
      end
    end else begin
      mcnt = (mcnt + 1) % DIV;
      if (mse) begin msel = 0; mph = "idle"; end
    end
  endtask

  task automatic step(input bit r, input int v);
    run = r;
    V = 4'(v);
    @(posedge clk);
    model_edge(rstn, r, v);
    #1;
    chk("clk_en", 32'(clk_en), 32'((mph != "idle") && mcnt == DIV - 1));
    chk("busy", 32'(busy), 32'(mph != "idle"));
    chk("sel", 32'(sel), 32'(msel));
    chk("ptr", 32'(ptr), 32'(mptr));
    chk("v_err", 32'(v_err), 32'(mverr));
    chk("dither", 32'(dither), ml[0] ? 32'd1 : 32'd3);
  endtask

  task automatic strobe_step(input bit r, input int v);
    int n = 0;
    do begin step(r, v); n++; end while (!mse && n < 2 * DIV);
    chk("strobe_wait", 32'(mse), 32'd1);
  endtask

  task automatic wait_run(input int v);
    int n = 0;
    while (mph != "run" && n < 200) begin step(1, v); n++; end
    chk("reach_run", 32'(mph == "run"), 32'd1);
  endtask

  initial begin
    bit   r;
    int   n;
    logic [7:0] held;
    // reset with run high
    rstn = 0;
    repeat (3) step(1, 5);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_v_err", 32'(v_err), 32'd0);
    chk("rst_dither", 32'(dither), 32'd1);
    rstn = 1;
    step(1, 3);
    chk("busy_after_release", 32'(busy), 32'd1);
    // warmup then DWA rotation
    repeat (WARMUP) begin
      strobe_step(1, 3);
      chk("warm_sel", 32'(sel), 32'd0);
    end
    strobe_step(1, 3);
    chk("run1_sel", 32'(sel), 32'h07); chk("run1_ptr", 32'(ptr), 32'd3);
    strobe_step(1, 3);
    chk("run2_sel", 32'(sel), 32'h38); chk("run2_ptr", 32'(ptr), 32'd6);
    strobe_step(1, 3);
    chk("run3_sel", 32'(sel), 32'hC1); chk("run3_ptr", 32'(ptr), 32'd1);
    strobe_step(1, 8);
    chk("full_sel", 32'(sel), 32'hFF); chk("full_ptr", 32'(ptr), 32'd1);
    strobe_step(1, 0);
    chk("zero_sel", 32'(sel), 32'h00); chk("zero_ptr", 32'(ptr), 32'd1);
    chk("no_err_yet", 32'(v_err), 32'd0);
    strobe_step(1, 12);
    chk("sat_sel", 32'(sel), 32'hFF); chk("sat_ptr", 32'(ptr), 32'd1);
    chk("sat_err", 32'(v_err), 32'd1);
    strobe_step(1, 2);
    chk("post_sat_sel", 32'(sel), 32'h06); chk("post_sat_ptr", 32'(ptr), 32'd3);
    chk("err_sticky", 32'(v_err), 32'd1);
    // randomized run/stop traffic, toggles kept off strobe edges
    r = 1;
    for (int i = 0; i < 1500; i++) begin
      if (mcnt != DIV - 1 && $urandom_range(59, 0) == 0) r = !r;
      step(r, int'($urandom_range(10, 0)));
    end
    // stop mid-RUN: sel held until the next strobe, then all off
    wait_run(1);
    strobe_step(1, 3);
    held = msel;
    chk("pre_drain_sel", 32'(sel), 32'(held));
    n = 0;
    do begin
      step(0, 3);
      if (mph == "drain") chk("drain_hold", 32'(sel), 32'(held));
      n++;
    end while (mph != "idle" && n < 2 * DIV);
    chk("drain_sel", 32'(sel), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    repeat (12) begin
      step(0, 5);
      chk("idle_no_strobe", 32'(clk_en), 32'd0);
    end
    // stop during WARMUP
    repeat (3) step(1, 0);
    chk("warm_busy", 32'(busy), 32'd1);
    step(0, 0);
    chk("warm_abort_busy", 32'(busy), 32'd0);
    // reset mid-RUN with ptr=6
    wait_run(0);
    strobe_step(1, (6 - mptr + N) % N);
    chk("pre_rst_ptr", 32'(ptr), 32'd6);
    rstn = 0;
    step(1, 4);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_ptr", 32'(ptr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dither", 32'(dither), 32'd1);
    rstn = 1;
    repeat (100) step(1, int'($urandom_range(9, 0)));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/dem_dwa_sched.md
Name: dem_dwa_sched

Overview:
- Sample-rate scheduler for the DAC digital back end.
- Generates the clk_en sample strobe and the ±1 dither stream consumed by the decouple sequence generators.
- Converts the per-sample element count V into a data-weighted-averaging (DWA) rotated unit-element select mask for an N-element array.
- Runs an IDLE/WARMUP/RUN/DRAIN FSM so the element array only switches after the dither LFSR and shaping loops have settled, and returns to all-off cleanly.

Parameters:
- N_ELEM, 8: number of unit elements; power of 2, 4..16.
- PTR_W, 3: log2(N_ELEM).
- DIV, 4: clk cycles per sample strobe; minimum 2.
- WARMUP, 16: sample strobes spent in WARMUP before RUN; minimum 1.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- run  in  1  level; 1 = start/continue conversion, 0 = stop.
- V  in  PTR_W+1  unsigned element count for the next sample, 0..N_ELEM.
- clk_en  out  1  sample strobe, one clk cycle wide.
- dither  out  2  signed ±1 (2'b01 = +1, 2'b11 = -1).
- sel  out  N_ELEM  element select mask; bit i drives element i.
- ptr  out  PTR_W  current DWA rotation pointer.
- busy  out  1  1 when state != IDLE.
- v_err  out  1  sticky flag: V > N_ELEM was sampled.

Behaviour:
- Reset (rstn=0 at a clk edge) produces, on that edge:
  - state=IDLE, cnt=0, warm_cnt=0, ptr=0, sel=0, lfsr=SEED, v_err=0.
  - Outputs follow: clk_en=0, busy=0, dither from lfsr[0] (SEED lsb 1 gives 2'b01).
  - Reset mid-operation behaves identically; no drain is performed.
- Divider:
  - IDLE: cnt held at 0.
  - Any other state: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
  - clk_en = (state!=IDLE) && (cnt==DIV-1), decoded from registers.
  - The first strobe is high during the DIV-th cycle after entering WARMUP.
  - A "strobe edge" is a clk edge where clk_en=1.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts toward bit 0.
  - Advances on every strobe edge in WARMUP and RUN only; holds in IDLE and DRAIN.
  - dither = lfsr[0] ? 2'b01 : 2'b11.
- FSM:
  - IDLE: run=1 -> WARMUP, cnt=0, warm_cnt=0.
  - WARMUP:
    - run=0 at any edge -> IDLE at that edge; cnt and warm_cnt cleared, sel stays 0.
    - Otherwise warm_cnt increments on each strobe edge.
    - On the WARMUP-th strobe edge -> RUN; sel and ptr not updated on this edge.
  - RUN, on each strobe edge with run=1:
    - Ve = min(V, N_ELEM).
    - sel[(ptr+k) mod N_ELEM] = 1 for k=0..Ve-1, all other bits 0.
    - ptr <= (ptr+Ve) mod N_ELEM.
  - RUN, when run=0 at any edge: -> DRAIN; sel held.
  - DRAIN: at the next strobe edge sel <= 0, state -> IDLE; ptr retained. run is ignored in DRAIN.
  - Restarting from IDLE keeps the previous ptr; only reset clears it.
- V handling:
  - V is sampled only on RUN strobe edges.
  - V==0: sel=0, ptr unchanged.
  - V==N_ELEM: sel all ones, ptr unchanged (mod wrap).
  - V>N_ELEM: saturate to N_ELEM; v_err <= 1, cleared only by reset.
- Arithmetic: pointer sum computed at PTR_W+1 bits, then reduced mod N_ELEM by truncation.
- Outputs are glitch-free registered values except clk_en and busy, which are decoded from registered state.

Optional Feature:
- Macro: DEM_PTR_DITHER_EN.
- Defined: in RUN, ptr <= (ptr+Ve+lfsr[1]) mod N_ELEM, sampled before the LFSR shift on that edge. This randomises the rotation to break DWA idle tones. sel is unaffected for the current sample.
- Undefined: ptr <= (ptr+Ve) mod N_ELEM exactly; lfsr[1] is unused.

Test Plan (N_ELEM=8, DIV=4, WARMUP=16, SEED=16'hACE1, macro undefined):
1. rstn=0 for 3 clk with run=1, V=5 -> sel=0, ptr=0, clk_en=0, busy=0, v_err=0, dither=2'b01; after release with run=1, busy=1 one edge later.
2. run=1, V=3 -> clk_en period 4 clk; sel stays 0 for 16 strobes; then successive RUN strobes give sel=8'b0000_0111 ptr=3, sel=8'b0011_1000 ptr=6, sel=8'b1100_0001 ptr=1.
3. In RUN, V=8 -> sel=8'hFF, ptr unchanged; then V=0 -> sel=8'h00, ptr unchanged.
4. In RUN with ptr=1, V=12 -> sel=8'hFF, ptr=1, v_err=1; then V=2 -> sel=8'b0000_0110, v_err remains 1.
5. run=0 mid-RUN -> sel held until the next strobe edge, then sel=0 and busy=0; no further clk_en pulses; LFSR state frozen. run=0 during WARMUP -> IDLE on the next edge.
6. rstn=0 for 1 clk mid-RUN (ptr=6) -> next edge sel=0, ptr=0, lfsr=SEED, state IDLE.
